// File: rtl/lc3_ctrl_pkg.sv
// Shared definitions for the LC-3 multi-cycle controller:
// the state encoding, opcodes and datapath select encodings.
package lc3_ctrl_pkg;

  typedef enum logic [4:0] {
    S_FETCH0, S_FETCH1, S_FETCH2, S_DECODE,
    S_ALU, S_BR, S_JSR0, S_JSR1, S_JMP, S_LEA,
    S_ADR, S_IND0, S_IND1, S_RD, S_WB, S_STD, S_WR,
    S_HALT
  } state_e;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOT  = 2'b11;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_EAB = 2'b01;

  localparam logic [1:0] EAB2_ZERO  = 2'b00;
  localparam logic [1:0] EAB2_OFF6  = 2'b01;
  localparam logic [1:0] EAB2_OFF9  = 2'b10;
  localparam logic [1:0] EAB2_OFF11 = 2'b11;

  // States that hold for MEM_WAIT+1 cycles on a memory access.
  function automatic logic is_wait_state(input state_e s);
    return (s == S_FETCH1) || (s == S_IND0) || (s == S_RD) || (s == S_WR);
  endfunction

endpackage

// File: rtl/lc3_wait_counter.sv
// Memory wait-state counter: counts while start_i is high and flags
// the final cycle of a MEM_WAIT+1 cycle access.
module lc3_wait_counter #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic clear_i,
  output logic done_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    if (clear_i) begin
      cnt_d = 4'd0;
    end else if (start_i) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = start_i && (cnt_q == 4'(MEM_WAIT));

endmodule

// File: rtl/lc3_controller_p.sv
// Parametrised multi-cycle LC-3 control unit with memory wait states,
// full addressing modes, run/halt handshake and retired-instruction counter.
module lc3_controller_p
  import lc3_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT  = 0,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          IR,
  input  logic                 N,
  input  logic                 Z,
  input  logic                 P,
  input  logic                 run,
  output logic [1:0]           aluControl,
  output logic                 enaALU,
  output logic                 enaMARM,
  output logic                 enaPC,
  output logic                 enaMDR,
  output logic [2:0]           SR1,
  output logic [2:0]           SR2,
  output logic [2:0]           DR,
  output logic                 regWE,
  output logic                 flagWE,
  output logic                 memWE,
  output logic                 ldPC,
  output logic                 ldIR,
  output logic                 ldMAR,
  output logic                 ldMDR,
  output logic [1:0]           selPC,
  output logic                 selEAB1,
  output logic [1:0]           selEAB2,
  output logic                 selMDR,
  output logic                 halted,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] retired
);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] retired_q;
  logic                 illegal_q;
  logic                 wait_st_s, wait_done_s, wait_clr_s, retire_s;
  logic [3:0]           op_s;
  logic                 unused_ir_s;

  assign op_s        = IR[15:12];
  assign unused_ir_s = ^IR[5:3];
  assign wait_st_s   = is_wait_state(state_q);
  assign wait_clr_s  = wait_done_s || !wait_st_s;

  lc3_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .clk     (clk),
    .rst_n   (reset),
    .start_i (wait_st_s),
    .clear_i (wait_clr_s),
    .done_o  (wait_done_s)
  );

  always_comb begin
    state_d    = state_q;
    aluControl = ALU_PASS;
    enaALU     = 1'b0;
    enaMARM    = 1'b0;
    enaPC      = 1'b0;
    enaMDR     = 1'b0;
    SR1        = IR[11:9];
    SR2        = IR[2:0];
    DR         = IR[11:9];
    regWE      = 1'b0;
    flagWE     = 1'b0;
    memWE      = 1'b0;
    ldPC       = 1'b0;
    ldIR       = 1'b0;
    ldMAR      = 1'b0;
    ldMDR      = 1'b0;
    selPC      = PC_INC;
    selEAB1    = 1'b0;
    selEAB2    = EAB2_ZERO;
    selMDR     = 1'b0;
    halted     = 1'b0;
    case (state_q)
      S_FETCH0: begin
        enaPC   = 1'b1;
        ldMAR   = 1'b1;
        state_d = run ? S_FETCH1 : S_FETCH0;
      end
      S_FETCH1: begin
        selMDR  = 1'b1;
        ldMDR   = wait_done_s;
        ldPC    = wait_done_s;
        state_d = wait_done_s ? S_FETCH2 : S_FETCH1;
      end
      S_FETCH2: begin
        enaMDR  = 1'b1;
        ldIR    = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (op_s)
          OP_ADD, OP_AND, OP_NOT:                 state_d = S_ALU;
          OP_BR:                                  state_d = S_BR;
          OP_JSR:                                 state_d = S_JSR0;
          OP_JMP:                                 state_d = S_JMP;
          OP_LEA:                                 state_d = S_LEA;
          OP_LD, OP_LDR, OP_LDI, OP_ST, OP_STR, OP_STI: state_d = S_ADR;
          default:                                state_d = S_HALT;
        endcase
      end
      S_ALU: begin
        case (op_s)
          OP_ADD:  aluControl = ALU_ADD;
          OP_AND:  aluControl = ALU_AND;
          default: aluControl = ALU_NOT;
        endcase
        SR1     = IR[8:6];
        enaALU  = 1'b1;
        regWE   = 1'b1;
        flagWE  = 1'b1;
        state_d = S_FETCH0;
      end
      S_BR: begin
        selPC   = PC_EAB;
        selEAB2 = EAB2_OFF9;
        ldPC    = (N & IR[11]) | (Z & IR[10]) | (P & IR[9]);
        state_d = S_FETCH0;
      end
      S_JSR0: begin
        enaPC   = 1'b1;
        regWE   = 1'b1;
        DR      = 3'd7;
        state_d = S_JSR1;
      end
      S_JSR1: begin
        ldPC  = 1'b1;
        selPC = PC_EAB;
        if (IR[11]) begin
          selEAB2 = EAB2_OFF11;
        end else begin
          selEAB1 = 1'b1;
          SR1     = IR[8:6];
        end
        state_d = S_FETCH0;
      end
      S_JMP: begin
        ldPC    = 1'b1;
        selPC   = PC_EAB;
        selEAB1 = 1'b1;
        SR1     = IR[8:6];
        state_d = S_FETCH0;
      end
      S_LEA: begin
        enaMARM = 1'b1;
        selEAB2 = EAB2_OFF9;
        regWE   = 1'b1;
        state_d = S_FETCH0;
      end
      S_ADR: begin
        enaMARM = 1'b1;
        ldMAR   = 1'b1;
        if ((op_s == OP_LDR) || (op_s == OP_STR)) begin
          selEAB1 = 1'b1;
          selEAB2 = EAB2_OFF6;
          SR1     = IR[8:6];
        end else begin
          selEAB2 = EAB2_OFF9;
        end
        case (op_s)
          OP_LDI, OP_STI: state_d = S_IND0;
          OP_LD, OP_LDR:  state_d = S_RD;
          default:        state_d = S_STD;
        endcase
      end
      S_IND0: begin
        selMDR  = 1'b1;
        ldMDR   = wait_done_s;
        state_d = wait_done_s ? S_IND1 : S_IND0;
      end
      S_IND1: begin
        enaMDR  = 1'b1;
        ldMAR   = 1'b1;
        state_d = (op_s == OP_LDI) ? S_RD : S_STD;
      end
      S_RD: begin
        selMDR  = 1'b1;
        ldMDR   = wait_done_s;
        state_d = wait_done_s ? S_WB : S_RD;
      end
      S_WB: begin
        enaMDR  = 1'b1;
        regWE   = 1'b1;
        flagWE  = 1'b1;
        state_d = S_FETCH0;
      end
      S_STD: begin
        enaALU  = 1'b1;
        ldMDR   = 1'b1;
        state_d = S_WR;
      end
      S_WR: begin
        memWE   = wait_done_s;
        state_d = wait_done_s ? S_FETCH0 : S_WR;
      end
      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH0;
      end
    endcase
  end

  // Every instruction completes by returning to FETCH0; HALT never does.
  assign retire_s = (state_d == S_FETCH0) && (state_q != S_FETCH0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH0;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire_s) begin
        retired_q <= retired_q + CNT_WIDTH'(1);
      end
      if ((state_q == S_DECODE) && ((op_s == OP_RTI) || (op_s == OP_RES))) begin
        illegal_q <= 1'b1;
      end
    end
  end

  assign retired = retired_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_lc3_controller_p.sv
// Directed bench for lc3_controller_p: one instance with MEM_WAIT=0 and
// one with MEM_WAIT=3 (narrow counter to exercise wrap) run side by side.
module tb_lc3_controller_p;

  typedef struct packed {
    logic [1:0] alu;
    logic ena_alu, ena_marm, ena_pc, ena_mdr;
    logic [2:0] sr1, sr2, dr;
    logic reg_we, flag_we, mem_we, ld_pc, ld_ir, ld_mar, ld_mdr;
    logic [1:0] sel_pc;
    logic sel_eab1;
    logic [1:0] sel_eab2;
    logic sel_mdr, halted, illegal;
  } obs_t;

  logic clk = 1'b0, reset = 1'b0, run = 1'b0, N = 1'b0, Z = 1'b0, P = 1'b0;
  logic [15:0] IR = 16'h0000;
  always #5 clk = ~clk;

  logic [1:0] alu_a, alu_b, selpc_a, selpc_b, eab2_a, eab2_b;
  logic [2:0] sr1_a, sr1_b, sr2_a, sr2_b, dr_a, dr_b;
  logic ealu_a, ealu_b, emarm_a, emarm_b, epc_a, epc_b, emdr_a, emdr_b;
  logic rwe_a, rwe_b, fwe_a, fwe_b, mwe_a, mwe_b, ldpc_a, ldpc_b, ldir_a, ldir_b;
  logic ldmar_a, ldmar_b, ldmdr_a, ldmdr_b, eab1_a, eab1_b, smdr_a, smdr_b;
  logic hlt_a, hlt_b, ill_a, ill_b;
  logic [15:0] retired_a;
  logic [2:0]  retired_b;

  lc3_controller_p #(.MEM_WAIT(0), .CNT_WIDTH(16)) u_dut_a (
    .clk(clk), .reset(reset), .IR(IR), .N(N), .Z(Z), .P(P), .run(run),
    .aluControl(alu_a), .enaALU(ealu_a), .enaMARM(emarm_a), .enaPC(epc_a), .enaMDR(emdr_a),
    .SR1(sr1_a), .SR2(sr2_a), .DR(dr_a), .regWE(rwe_a), .flagWE(fwe_a), .memWE(mwe_a),
    .ldPC(ldpc_a), .ldIR(ldir_a), .ldMAR(ldmar_a), .ldMDR(ldmdr_a), .selPC(selpc_a),
    .selEAB1(eab1_a), .selEAB2(eab2_a), .selMDR(smdr_a), .halted(hlt_a), .illegal(ill_a),
    .retired(retired_a));

  lc3_controller_p #(.MEM_WAIT(3), .CNT_WIDTH(3)) u_dut_b (
    .clk(clk), .reset(reset), .IR(IR), .N(N), .Z(Z), .P(P), .run(run),
    .aluControl(alu_b), .enaALU(ealu_b), .enaMARM(emarm_b), .enaPC(epc_b), .enaMDR(emdr_b),
    .SR1(sr1_b), .SR2(sr2_b), .DR(dr_b), .regWE(rwe_b), .flagWE(fwe_b), .memWE(mwe_b),
    .ldPC(ldpc_b), .ldIR(ldir_b), .ldMAR(ldmar_b), .ldMDR(ldmdr_b), .selPC(selpc_b),
    .selEAB1(eab1_b), .selEAB2(eab2_b), .selMDR(smdr_b), .halted(hlt_b), .illegal(ill_b),
    .retired(retired_b));

  obs_t        ob  [2];
  logic [15:0] ret [2];

  assign ob[0] = '{alu: alu_a, ena_alu: ealu_a, ena_marm: emarm_a, ena_pc: epc_a, ena_mdr: emdr_a,
                   sr1: sr1_a, sr2: sr2_a, dr: dr_a, reg_we: rwe_a, flag_we: fwe_a, mem_we: mwe_a,
                   ld_pc: ldpc_a, ld_ir: ldir_a, ld_mar: ldmar_a, ld_mdr: ldmdr_a, sel_pc: selpc_a,
                   sel_eab1: eab1_a, sel_eab2: eab2_a, sel_mdr: smdr_a, halted: hlt_a, illegal: ill_a};
  assign ob[1] = '{alu: alu_b, ena_alu: ealu_b, ena_marm: emarm_b, ena_pc: epc_b, ena_mdr: emdr_b,
                   sr1: sr1_b, sr2: sr2_b, dr: dr_b, reg_we: rwe_b, flag_we: fwe_b, mem_we: mwe_b,
                   ld_pc: ldpc_b, ld_ir: ldir_b, ld_mar: ldmar_b, ld_mdr: ldmdr_b, sel_pc: selpc_b,
                   sel_eab1: eab1_b, sel_eab2: eab2_b, sel_mdr: smdr_b, halted: hlt_b, illegal: ill_b};
  assign ret[0] = retired_a;
  assign ret[1] = {13'd0, retired_b};

  int n_cmp = 0, n_bad = 0;
  int lat [2], n_ldmdr [2], mdr1 [2], mdr2 [2], n_memwe [2], we_cyc [2], n_brpc [2], n_flag [2];
  logic [1:0] alu_seen [2], eab2_seen [2];
  logic [2:0] dr_seen [2], sr1_seen [2], sr2_seen [2], pc_sr1 [2], dr7 [2];
  logic       eab1_seen [2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic sample(input int k, input int c);
    obs_t o;
    o = ob[k];
    if (o.ld_mdr) begin
      n_ldmdr[k]++;
      if (n_ldmdr[k] == 1) mdr1[k] = c;
      else mdr2[k] = c;
    end
    if (o.mem_we) begin
      n_memwe[k]++;
      we_cyc[k] = c;
    end
    if (o.ld_pc && o.sel_pc == 2'b01) begin
      n_brpc[k]++;
      eab1_seen[k] = o.sel_eab1;
      eab2_seen[k] = o.sel_eab2;
      pc_sr1[k]    = o.sr1;
    end
    if (o.flag_we) n_flag[k]++;
    if (o.ena_alu && o.reg_we) begin
      alu_seen[k] = o.alu;
      dr_seen[k]  = o.dr;
      sr1_seen[k] = o.sr1;
      sr2_seen[k] = o.sr2;
    end
    if (o.ena_pc && o.reg_we) dr7[k] = o.dr;
  endtask

  // Reset, then run one instruction on both instances until each retires it.
  task automatic run_instr(input logic [15:0] ir, input logic n, input logic z, input logic p);
    IR = ir; N = n; Z = z; P = p; run = 1'b1;
    for (int k = 0; k < 2; k++) begin
      lat[k] = 0; n_ldmdr[k] = 0; mdr1[k] = 0; mdr2[k] = 0; n_memwe[k] = 0; we_cyc[k] = 0;
      n_brpc[k] = 0; n_flag[k] = 0; alu_seen[k] = 2'b00; eab2_seen[k] = 2'b00; eab1_seen[k] = 1'b0;
      dr_seen[k] = 3'd0; sr1_seen[k] = 3'd0; sr2_seen[k] = 3'd0; pc_sr1[k] = 3'd0; dr7[k] = 3'd0;
    end
    do_reset();
    for (int c = 1; c <= 60; c++) begin
      for (int k = 0; k < 2; k++) if (lat[k] == 0) sample(k, c);
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) if (lat[k] == 0 && ret[k] != 16'd0) lat[k] = c;
      if (lat[0] != 0 && lat[1] != 0) break;
      @(negedge clk);
    end
  endtask

  initial begin
    int w;
    int held [2];
    reset = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("rst_enapc_%0d", k), ob[k].ena_pc, 1);
      check_val($sformatf("rst_ldmar_%0d", k), ob[k].ld_mar, 1);
      check_val($sformatf("rst_other_%0d", k),
                {ob[k].ena_alu, ob[k].ena_marm, ob[k].ena_mdr, ob[k].reg_we, ob[k].flag_we,
                 ob[k].mem_we, ob[k].ld_pc, ob[k].ld_ir, ob[k].ld_mdr, ob[k].halted, ob[k].illegal}, 0);
      check_val($sformatf("rst_ret_%0d", k), ret[k], 0);
    end

    run_instr(16'h1042, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      w = 3 * k;
      check_val($sformatf("add_lat_%0d", k), lat[k], 5 + w);
      check_val($sformatf("add_alu_%0d", k), alu_seen[k], 1);
      check_val($sformatf("add_dr_%0d", k), dr_seen[k], 0);
      check_val($sformatf("add_sr1_%0d", k), sr1_seen[k], 1);
      check_val($sformatf("add_sr2_%0d", k), sr2_seen[k], 2);
      check_val($sformatf("add_flag_%0d", k), n_flag[k], 1);
      check_val($sformatf("add_ret_%0d", k), ret[k], 1);
    end

    run_instr(16'h5042, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) check_val($sformatf("and_alu_%0d", k), alu_seen[k], 2);
    run_instr(16'h927F, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("not_alu_%0d", k), alu_seen[k], 3);
      check_val($sformatf("not_dr_%0d", k), dr_seen[k], 1);
    end

    run_instr(16'h2600, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      w = 3 * k;
      check_val($sformatf("ld_lat_%0d", k), lat[k], 7 + 2 * w);
      check_val($sformatf("ld_nmdr_%0d", k), n_ldmdr[k], 2);
      check_val($sformatf("ld_mdr1_%0d", k), mdr1[k], 2 + w);
      check_val($sformatf("ld_mdr2_%0d", k), mdr2[k], 6 + 2 * w);
    end

    run_instr(16'h3600, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      w = 3 * k;
      check_val($sformatf("st_lat_%0d", k), lat[k], 7 + 2 * w);
      check_val($sformatf("st_nwe_%0d", k), n_memwe[k], 1);
      check_val($sformatf("st_wecyc_%0d", k), we_cyc[k], 7 + 2 * w);
    end

    run_instr(16'hA600, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("ldi_lat_%0d", k), lat[k], 9 + 9 * k);
      check_val($sformatf("ldi_nmdr_%0d", k), n_ldmdr[k], 3);
    end

    run_instr(16'hB7FF, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("sti_lat_%0d", k), lat[k], 9 + 9 * k);
      check_val($sformatf("sti_nwe_%0d", k), n_memwe[k], 1);
      check_val($sformatf("sti_wecyc_%0d", k), we_cyc[k], 9 + 9 * k);
      check_val($sformatf("sti_nmdr_%0d", k), n_ldmdr[k], 3);
    end

    run_instr(16'h0405, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("brz0_lat_%0d", k), lat[k], 5 + 3 * k);
      check_val($sformatf("brz0_ldpc_%0d", k), n_brpc[k], 0);
    end
    run_instr(16'h0405, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("brz1_ldpc_%0d", k), n_brpc[k], 1);
      check_val($sformatf("brz1_eab_%0d", k), {eab1_seen[k], eab2_seen[k]}, 3'b010);
    end

    run_instr(16'h4800, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("jsr_lat_%0d", k), lat[k], 6 + 3 * k);
      check_val($sformatf("jsr_ldpc_%0d", k), n_brpc[k], 1);
      check_val($sformatf("jsr_eab_%0d", k), {eab1_seen[k], eab2_seen[k]}, 3'b011);
      check_val($sformatf("jsr_dr7_%0d", k), dr7[k], 7);
    end
    run_instr(16'h4080, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("jsrr_eab_%0d", k), {eab1_seen[k], eab2_seen[k]}, 3'b100);
      check_val($sformatf("jsrr_sr1_%0d", k), pc_sr1[k], 2);
    end

    run_instr(16'hC1C0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("jmp_lat_%0d", k), lat[k], 5 + 3 * k);
      check_val($sformatf("jmp_eab_%0d", k), {eab1_seen[k], eab2_seen[k]}, 3'b100);
      check_val($sformatf("jmp_sr1_%0d", k), pc_sr1[k], 7);
    end

    run_instr(16'hE5FF, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("lea_lat_%0d", k), lat[k], 5 + 3 * k);
      check_val($sformatf("lea_flag_%0d", k), n_flag[k], 0);
    end

    IR = 16'hD000; run = 1'b1;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      run = ~run;
    end
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("ill_halted_%0d", k), ob[k].halted, 1);
      check_val($sformatf("ill_flag_%0d", k), ob[k].illegal, 1);
      check_val($sformatf("ill_ret_%0d", k), ret[k], 0);
      check_val($sformatf("ill_enapc_%0d", k), ob[k].ena_pc, 0);
    end
    reset = 1'b0; #1;
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("ill_rst_state_%0d", k), {ob[k].halted, ob[k].illegal, ob[k].ena_pc}, 3'b001);
      check_val($sformatf("ill_rst_ret_%0d", k), ret[k], 0);
    end

    IR = 16'hF025; run = 1'b1;
    do_reset();
    repeat (20) @(negedge clk);
    for (int k = 0; k < 2; k++)
      check_val($sformatf("trap_halt_%0d", k), {ob[k].halted, ob[k].illegal}, 2'b10);

    IR = 16'h1042; run = 1'b0;
    do_reset();
    held[0] = 0; held[1] = 0;
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 2; k++)
        if (ob[k].ena_pc && ob[k].ld_mar && !ob[k].sel_mdr) held[k]++;
      @(negedge clk);
    end
    for (int k = 0; k < 2; k++) check_val($sformatf("run0_held_%0d", k), held[k], 10);
    run = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++)
      check_val($sformatf("run1_fetch1_%0d", k), {ob[k].sel_mdr, ob[k].ena_pc}, 2'b10);

    IR = 16'h1042; run = 1'b1;
    do_reset();
    repeat (72) @(posedge clk);
    #1;
    check_val("wrap_ret_0", ret[0], 14);
    check_val("wrap_ret_1", ret[1], 1);

    IR = 16'h3600; run = 1'b1;
    do_reset();
    repeat (11) @(posedge clk);
    #1;
    reset = 1'b0; #1;
    check_val("abort_state_1", {ob[1].mem_we, ob[1].ena_pc, ob[1].ld_mar}, 3'b011);
    held[1] = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ob[1].mem_we) held[1]++;
    end
    check_val("abort_nowe_1", held[1], 0);
    reset = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lc3_controller_p.md
# lc3_controller_p

Parametrised multi-cycle LC-3 control unit, the successor to the fixed-timing Lab 12 controller. It drives the datapath select, enable and load lines from the IR and the N/Z/P flags. It adds:
- configurable memory wait states;
- full addressing modes (LDR, STR, LEA, LDI, STI, JSRR);
- a run/halt handshake;
- a retired-instruction counter.

## Interface
- MEM_WAIT, 0: extra cycles each memory read or write is held (0..15).
- CNT_WIDTH, 16: width of the retired-instruction counter.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low.
- IR  in  16  current instruction.
- N, Z, P  in  1 each  condition flags.
- run  in  1  permits a new fetch; sampled in FETCH0.
- aluControl  out  2  00 pass A, 01 ADD, 10 AND, 11 NOT.
- enaALU, enaMARM, enaPC, enaMDR  out  1 each  bus drivers.
- SR1, SR2, DR  out  3 each  register addresses.
- regWE, flagWE, memWE  out  1 each  write enables.
- ldPC, ldIR, ldMAR, ldMDR  out  1 each  register loads.
- selPC  out  2  00 PC+1, 01 EAB.
- selEAB1  out  1  0 PC, 1 SR1.
- selEAB2  out  2  00 zero, 01 off6, 10 off9, 11 off11.
- selMDR  out  1  1 memory, 0 bus.
- halted  out  1  controller is in HALT.
- illegal  out  1  HALT was entered on opcode 1000 or 1101.
- retired  out  CNT_WIDTH  count of completed instructions.

## Operation
- Moore FSM with encoded states:
  - FETCH0, FETCH1, FETCH2, DECODE;
  - ALU, BR, JSR0, JSR1, JMP, LEA;
  - ADR, IND0, IND1, RD, WB, STD, WR;
  - HALT.
- Fetch:
  - FETCH0: enaPC, ldMAR. Go to FETCH1 if run=1, else stay.
  - FETCH1: selMDR=1, selPC=00. Waits MEM_WAIT cycles; ldMDR and ldPC pulse on the final cycle only.
  - FETCH2: enaMDR, ldIR.
- DECODE branches on IR[15:12]:
  - 0001/0101/1001 → ALU;
  - 0000 → BR;
  - 0100 → JSR0;
  - 1100 → JMP;
  - 1110 → LEA;
  - 0010/0110/1010/0011/0111/1011 → ADR;
  - 1111 → HALT;
  - 1000/1101 → HALT with illegal latched to 1.
- ALU: aluControl per opcode, SR1=IR[8:6], SR2=IR[2:0], DR=IR[11:9], enaALU, regWE, flagWE.
- BR: selPC=01, selEAB1=0, selEAB2=10. ldPC only if (N&IR[11])|(Z&IR[10])|(P&IR[9]).
- JSR0: enaPC, regWE, DR=7.
- JSR1: ldPC, selPC=01.
  - IR[11]=1: selEAB1=0, selEAB2=11.
  - IR[11]=0: selEAB1=1, selEAB2=00, SR1=IR[8:6].
- JMP: ldPC, selPC=01, selEAB1=1, selEAB2=00, SR1=IR[8:6].
- LEA: enaMARM, selEAB1=0, selEAB2=10, regWE, DR=IR[11:9]. No flagWE.
- ADR: enaMARM, ldMAR.
  - LDR/STR: selEAB1=1, selEAB2=01, SR1=IR[8:6].
  - Otherwise: selEAB1=0, selEAB2=10.
  - Next state: IND0 for LDI/STI; RD for LD/LDR; STD for ST/STR.
- IND0: read with wait, ldMDR on the final cycle.
- IND1: enaMDR, ldMAR. Next is RD for LDI, STD for STI.
- RD: read with wait, ldMDR on the final cycle.
- WB: enaMDR, regWE, flagWE, DR=IR[11:9].
- STD: SR1=IR[11:9], enaALU, aluControl=00, selMDR=0, ldMDR.
- WR: memWE on the final wait cycle only.
- HALT: all strobes 0, halted=1. Left only by reset.
- Return to FETCH0 from ALU, BR, JSR1, JMP, LEA, WB and WR.
- retired increments on each return to FETCH0, wrapping modulo 2^CNT_WIDTH.
- Outputs not listed for a state are 0. The default SR1 is IR[11:9], the default DR is IR[11:9], and SR2 is always IR[2:0].

## Timing
- Reset asserted: state=FETCH0, wait counter=0, retired=0, illegal=0.
  - Outputs during reset are the FETCH0 values: enaPC=1, ldMAR=1, all other strobes 0, halted=0.
- Reset asserted mid-access aborts immediately; no partial memWE is issued.
- Each wait state lasts MEM_WAIT+1 cycles. The counter clears on state exit.
- MEM_WAIT=0 gives single-cycle access, the original timing.
- Instruction latency in cycles, with W=MEM_WAIT:
  - ALU/BR/JMP/LEA: 5+W;
  - JSR: 6+W;
  - LD/LDR: 7+2W;
  - ST/STR: 7+2W;
  - LDI/STI: 9+3W.
- run=0 holds FETCH0 indefinitely, with enaPC and ldMAR still asserted (idempotent). run is ignored in all other states.

## Structure
- Package lc3_ctrl_pkg holds:
  - the state enum;
  - opcode constants;
  - aluControl, selPC and selEAB2 encodings.
- Sub-module lc3_wait_counter takes MEM_WAIT and provides start/clear inputs and a done output. The FSM instantiates one shared instance.

## Test plan
- MEM_WAIT=0, IR=0x1042 (ADD R0,R1,R2) → 5 cycles FETCH0→ALU. aluControl=01, regWE=flagWE=1, DR=0, SR1=1, SR2=2. retired becomes 1.
- MEM_WAIT=3, LD → ldMDR pulses once after 4 cycles in FETCH1 and once after 4 cycles in RD. Total 13 cycles.
- BRz with Z=0 → ldPC=0 in BR. Same instruction with Z=1 → ldPC=1, selPC=01.
- STI (IR=0xB7FF) → ADR, IND0, IND1, STD, WR. memWE is high exactly one cycle.
- IR=0xD000 → HALT, halted=1, illegal=1. run toggling has no effect; reset returns to FETCH0 with retired=0.
- run=0 after reset → state stays FETCH0 for 10 cycles. run=1 → FETCH1 on the next edge.
